// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry elastic FIFO between instruction fetch and decode.
// Entry0 is the head shown to decode; entry1 absorbs one extra fetch while decode stalls.
module if_id_buffer #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'('h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [PC_WIDTH-1:0]    if_PC,
  input  logic [INSTR_WIDTH-1:0] if_Instr,
  input  logic [PC_WIDTH-1:0]    if_PC_4,
  output logic                   if_ready,
  input  logic                   flush,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [PC_WIDTH-1:0]    id_PC,
  output logic [INSTR_WIDTH-1:0] id_Instr,
  output logic [PC_WIDTH-1:0]    id_PC_4,
  output logic [1:0]             count
);

  logic [1:0]             count_q, count_d;
  logic [PC_WIDTH-1:0]    e0_pc_q, e0_pc_d;
  logic [INSTR_WIDTH-1:0] e0_instr_q, e0_instr_d;
  logic [PC_WIDTH-1:0]    e0_pc4_q, e0_pc4_d;
  logic [PC_WIDTH-1:0]    e1_pc_q, e1_pc_d;
  logic [INSTR_WIDTH-1:0] e1_instr_q, e1_instr_d;
  logic [PC_WIDTH-1:0]    e1_pc4_q, e1_pc4_d;
  logic                   push;
  logic                   pop;

  // if_ready depends only on registered occupancy, never on id_ready
  assign if_ready = (count_q != 2'd2) & rst;
  assign id_valid = (count_q != 2'd0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  assign id_PC    = e0_pc_q;
  assign id_PC_4  = e0_pc4_q;
  assign id_Instr = id_valid ? e0_instr_q : NOP_INSTR;
  assign count    = count_q;

  always_comb begin
    count_d    = count_q;
    e0_pc_d    = e0_pc_q;
    e0_instr_d = e0_instr_q;
    e0_pc4_d   = e0_pc4_q;
    e1_pc_d    = e1_pc_q;
    e1_instr_d = e1_instr_q;
    e1_pc4_d   = e1_pc4_q;
    if (flush) begin
      count_d    = 2'd0;
      e0_pc_d    = '0;
      e0_instr_d = NOP_INSTR;
      e0_pc4_d   = '0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            e0_pc_d    = if_PC;
            e0_instr_d = if_Instr;
            e0_pc4_d   = if_PC_4;
            count_d    = 2'd1;
          end
        end
        2'd1: begin
          // Simultaneous push and pop replaces the head in place
          if (push && pop) begin
            e0_pc_d    = if_PC;
            e0_instr_d = if_Instr;
            e0_pc4_d   = if_PC_4;
          end else if (push) begin
            e1_pc_d    = if_PC;
            e1_instr_d = if_Instr;
            e1_pc4_d   = if_PC_4;
            count_d    = 2'd2;
          end else if (pop) begin
            count_d    = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
            e0_pc4_d   = e1_pc4_q;
            count_d    = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= 2'd0;
      e0_pc_q    <= '0;
      e0_instr_q <= NOP_INSTR;
      e0_pc4_q   <= '0;
      e1_pc_q    <= '0;
      e1_instr_q <= NOP_INSTR;
      e1_pc4_q   <= '0;
    end else begin
      count_q    <= count_d;
      e0_pc_q    <= e0_pc_d;
      e0_instr_q <= e0_instr_d;
      e0_pc4_q   <= e0_pc4_d;
      e1_pc_q    <= e1_pc_d;
      e1_instr_q <= e1_instr_d;
      e1_pc4_q   <= e1_pc4_d;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios then random valid/ready/flush
// traffic, checked every cycle against a queue-based scoreboard.
module tb_if_id_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } trip_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_PC;
  logic [31:0] if_Instr;
  logic [31:0] if_PC_4;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_PC;
  logic [31:0] id_Instr;
  logic [31:0] id_PC_4;
  logic [1:0]  count;

  trip_t cur;
  trip_t mq[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    m_zero = 1'b1;
  bit    acc;
  logic [31:0] pc;

  assign if_PC    = cur.pc;
  assign if_Instr = cur.instr;
  assign if_PC_4  = cur.pc4;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_PC    (if_PC),
    .if_Instr (if_Instr),
    .if_PC_4  (if_PC_4),
    .if_ready (if_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_PC    (id_PC),
    .id_Instr (id_Instr),
    .id_PC_4  (id_PC_4),
    .count    (count)
  );

  function automatic trip_t mk(input logic [31:0] p);
    trip_t t;
    t.pc    = p;
    t.instr = p ^ 32'h00C0_FFE3;
    t.pc4   = p + 32'd4;
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check if_ready before the edge, update scoreboard, check outputs after.
  task automatic tick();
    bit mrdy, push, pop;
    #2;
    mrdy = rst && (mq.size() != 2);
    check("if_ready", if_ready, mrdy);
    push = if_valid && mrdy && !flush;
    pop  = (mq.size() != 0) && id_ready && !flush;
    @(posedge clk);
    #1;
    acc = push;
    if (!rst || flush) begin
      mq.delete();
      m_zero = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(cur);
        m_zero = 1'b0;
      end
    end
    check("count", count, mq.size());
    check("id_valid", id_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("id_Instr", id_Instr, mq[0].instr);
      check("id_PC", id_PC, mq[0].pc);
      check("id_PC_4", id_PC_4, mq[0].pc4);
    end else begin
      check("id_Instr_nop", id_Instr, NOP);
      if (m_zero) begin
        check("id_PC_zero", id_PC, 0);
        check("id_PC_4_zero", id_PC_4, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
    cur = mk(32'h0);

    // Reset held for two cycles, then stream three instructions
    tick();
    check("rst_nop", id_Instr, NOP);
    tick();
    check("rst_count", count, 0);
    check("rst_ready", if_ready, 0);
    rst = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1;
      cur = mk(32'h8000_0000 + 32'(4 * i));
      tick();
      check("stream_pc", id_PC, 32'h8000_0000 + 32'(4 * i));
      check("stream_cnt", count, 1);
    end
    if_valid = 1'b0;
    tick();

    // Backpressure: A, B accepted, C held by fetch, then drained in order
    id_ready = 1'b0; if_valid = 1'b1;
    cur = mk(32'h0000_0A00); tick();
    cur = mk(32'h0000_0B00); tick();
    check("bp_count", count, 2);
    check("bp_rdy", if_ready, 0);
    cur = mk(32'h0000_0C00); tick();
    check("bp_head_a", id_PC, 32'h0000_0A00);
    id_ready = 1'b1;
    tick();
    check("bp_head_b", id_PC, 32'h0000_0B00);
    tick();
    check("bp_head_c", id_PC, 32'h0000_0C00);
    if_valid = 1'b0;
    tick();

    // Flush while full: D dropped, E arrives one cycle later
    id_ready = 1'b0; if_valid = 1'b1;
    cur = mk(32'h0000_1A00); tick();
    cur = mk(32'h0000_1B00); tick();
    cur = mk(32'h0000_1D00); flush = 1'b1;
    tick();
    check("fl_count", count, 0);
    check("fl_valid", id_valid, 0);
    check("fl_nop", id_Instr, NOP);
    check("fl_ready", if_ready, 1);
    flush = 1'b0; cur = mk(32'h0000_1E00);
    tick();
    check("fl_e", id_PC, 32'h0000_1E00);
    if_valid = 1'b0; id_ready = 1'b1;
    tick();

    // Push and pop at count 1
    id_ready = 1'b0; if_valid = 1'b1;
    cur = mk(32'h0000_2A00); tick();
    id_ready = 1'b1; cur = mk(32'h0000_2B00);
    tick();
    check("pp_count", count, 1);
    check("pp_head", id_PC, 32'h0000_2B00);
    if_valid = 1'b0;
    tick();

    // Reset while stalled and full
    id_ready = 1'b0; if_valid = 1'b1;
    cur = mk(32'h0000_3A00); tick();
    cur = mk(32'h0000_3B00); tick();
    cur = mk(32'h0000_3C00); rst = 1'b0;
    tick();
    check("mr_count", count, 0);
    check("mr_pc", id_PC, 0);
    check("mr_valid", id_valid, 0);
    rst = 1'b1; if_valid = 1'b0;
    #2;
    check("mr_ready", if_ready, 1);
    tick();

    // Random traffic; fetch holds its triple until accepted, redirects on flush
    pc = 32'h0000_1000;
    cur = mk(pc);
    repeat (10000) begin
      if_valid = ($urandom_range(0, 9) < 7);
      id_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 31) == 0);
      tick();
      if (flush) begin
        pc = {14'd0, 16'($urandom_range(0, 65535)), 2'b00};
        cur = mk(pc);
      end else if (acc) begin
        pc = pc + 32'd4;
        cur = mk(pc);
      end
    end
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
